redraw_scheduler: RTL and testbench

Upstream sequencer for the `erase_square` tile-restore stage. It queues grid-cell redraw requests from game logic, such as tower placement or enemy movement, in a small FIFO. It pops one cell at a time and drives `erase_square` through one 20×20 pass by gating its `resetn` and holding `COUNTER_X`/`COUNTER_Y` stable. It also generates the VGA `plot` strobe aligned with the stage's pixel/colour outputs.

---
 rtl/redraw_pkg.sv | 26 ++
 rtl/redraw_fifo.sv | 60 ++++++
 rtl/redraw_scheduler.sv | 137 +++++++++++++
 tb/tb_redraw_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/redraw_pkg.sv
// redraw_pkg: shared constants and types for the tile redraw sequencer.
// Pass timing is derived from the 20x20 tile so the numbers stay consistent.
package redraw_pkg;

  localparam int TILE        = 20;
  localparam int TILE_PIXELS = TILE * TILE;
  localparam int PLOT_FIRST  = 2;
  localparam int PLOT_LAST   = PLOT_FIRST + TILE_PIXELS - 1;
  localparam int CYC_TIMEOUT = PLOT_LAST + 1;
  localparam int DONE_MIN    = 2;

  localparam int GRID_W_DEF = 8;
  localparam int GRID_H_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    GAP   = 2'd2
  } rs_state_e;

  typedef struct packed {
    logic [3:0] gx;
    logic [3:0] gy;
  } cell_t;

endpackage

// File: rtl/redraw_fifo.sv
// redraw_fifo: small synchronous FIFO of queued redraw cells.
// Flushing only clears pointers/count; storage contents are don't-care.
module redraw_fifo
  import redraw_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  cell_t         din_i,
  output cell_t         dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  cell_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // cell storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/redraw_scheduler.sv
// redraw_scheduler: queues cell redraws and sequences one erase_square pass
// per cell, gating its resetn and generating the aligned VGA plot strobe.
module redraw_scheduler
  import redraw_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF,
  parameter int CW         = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_gx,
  input  logic [3:0]  req_gy,
  output logic        req_ready,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  output logic        erase_resetn,
  input  logic        erase_done,
  output logic        plot,
  output logic        busy,
  output logic        dropped,
  output logic        seq_error,
  output logic [CW:0] fifo_count
);

  localparam logic [8:0] CYC_ONE   = 9'd1;
  localparam logic [8:0] CYC_DMIN  = 9'(DONE_MIN);
  localparam logic [8:0] CYC_PLO   = 9'(PLOT_FIRST - 1);
  localparam logic [8:0] CYC_PHI   = 9'(PLOT_LAST - 1);
  localparam logic [8:0] CYC_WDOG  = 9'(CYC_TIMEOUT - 1);

  rs_state_e  state_q, state_d;
  logic [8:0] cyc_q, cyc_d;
  cell_t      cell_q, cell_d;
  logic       plot_q, plot_d;
  logic       drop_q, drop_d;
  logic       serr_q, serr_d;

  cell_t      head;
  logic       full;
  logic       empty;
  logic       in_range;
  logic       hs;
  logic       push;
  logic       pop;
  logic       done_ok;

  assign in_range = (int'(req_gx) < GRID_W) && (int'(req_gy) < GRID_H);
  assign req_ready = !full;
  assign hs        = req_valid && req_ready;
  assign push      = hs && in_range;
  assign drop_d    = hs && !in_range;
  assign done_ok   = erase_done && (cyc_q >= CYC_DMIN);

  redraw_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ('{gx: req_gx, gy: req_gy}),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // pass sequencing: pop, erase window with watchdog, one-cycle gap
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cell_d  = cell_q;
    serr_d  = serr_q;
    plot_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cell_d  = head;
          cyc_d   = '0;
          state_d = ERASE;
        end
      end
      ERASE: begin
        cyc_d = cyc_q + CYC_ONE;
        if (done_ok) begin
          state_d = GAP;
        end else if (cyc_q == CYC_WDOG) begin
          serr_d  = 1'b1;
          state_d = GAP;
        end
        plot_d = (state_d == ERASE) &&
                 (cyc_q >= CYC_PLO) &&
                 (cyc_q <= CYC_PHI);
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // sequencer state and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      cell_q  <= '0;
      plot_q  <= 1'b0;
      drop_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cell_q  <= cell_d;
      plot_q  <= plot_d;
      drop_q  <= drop_d;
      serr_q  <= serr_d;
    end
  end

  assign cell_x       = cell_q.gx;
  assign cell_y       = cell_q.gy;
  assign erase_resetn = (state_q == ERASE);
  assign plot         = plot_q;
  assign busy         = (state_q != IDLE) || !empty;
  assign dropped      = drop_q;
  assign seq_error    = serr_q;

endmodule

// File: tb/tb_redraw_scheduler.sv
// tb_redraw_scheduler: directed checks of queueing, pass timing,
// erase_done qualification, watchdog and reset behaviour.
module tb_redraw_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_gx;
  logic [3:0] req_gy;
  logic       req_ready;
  logic [3:0] cell_x;
  logic [3:0] cell_y;
  logic       erase_resetn;
  logic       erase_done = 1'b0;
  logic       plot;
  logic       busy;
  logic       dropped;
  logic       seq_error;
  logic [3:0] fifo_count;

  redraw_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_gx       (req_gx),
    .req_gy       (req_gy),
    .req_ready    (req_ready),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .erase_resetn (erase_resetn),
    .erase_done   (erase_done),
    .plot         (plot),
    .busy         (busy),
    .dropped      (dropped),
    .seq_error    (seq_error),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // erase_square done model: 0 normal, 1 stale-high, 2 never
  int done_mode = 0;
  int e_idx = 0;
  bit e_run = 1'b0;
  always @(negedge clk) begin
    if (erase_resetn) begin
      e_idx = e_run ? e_idx + 1 : 0;
      e_run = 1'b1;
    end else begin
      e_run = 1'b0;
    end
    case (done_mode)
      0: erase_done = erase_resetn && (e_idx == 401);
      1: erase_done = !erase_resetn || (e_idx <= 1) || (e_idx == 401);
      default: erase_done = 1'b0;
    endcase
  end

  // observation of passes
  int plot_cnt, plot_first, plot_last, seq_cyc, drop_cnt, unstable;
  int rise_q[$];
  int cx_q[$];
  int cy_q[$];
  bit er_prev = 1'b0;
  logic [3:0] lx, ly;
  always @(negedge clk) begin
    if (erase_resetn && !er_prev) begin
      rise_q.push_back(cyc_n);
      cx_q.push_back(int'(cell_x));
      cy_q.push_back(int'(cell_y));
      lx = cell_x;
      ly = cell_y;
    end
    if (erase_resetn && (cell_x !== lx || cell_y !== ly)) unstable++;
    if (plot) begin
      if (plot_first < 0) plot_first = cyc_n;
      plot_last = cyc_n;
      plot_cnt++;
    end
    if (seq_error && seq_cyc < 0) seq_cyc = cyc_n;
    if (dropped) drop_cnt++;
    er_prev = erase_resetn;
  end

  task automatic clr_mon();
    plot_cnt = 0; plot_first = -1; plot_last = -1;
    seq_cyc = -1; drop_cnt = 0; unstable = 0;
    rise_q.delete(); cx_q.delete(); cy_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y);
    req_valid = 1'b1;
    req_gx = 4'(x);
    req_gy = 4'(y);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(busy), 0);
  endtask

  int t0;
  int acc;
  int rdy_full;
  int n;

  initial begin
    clr_mon();
    reset = 1'b1; req_valid = 1'b0; req_gx = '0; req_gy = '0;
    step(); step();
    push(3, 2);
    step();
    check("rst_cell_x", int'(cell_x), 0);
    check("rst_cell_y", int'(cell_y), 0);
    check("rst_resetn", int'(erase_resetn), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(dropped), 0);
    check("rst_seq_error", int'(seq_error), 0);
    check("rst_count", int'(fifo_count), 0);
    reset = 1'b0;
    step();
    check("rst_push_ignored", int'(fifo_count), 0);

    // single request timing
    clr_mon();
    t0 = cyc_n;
    push(3, 2);
    wait_idle("t1_idle", 600);
    check("t1_busy_low_cyc", cyc_n, t0 + 405);
    check("t1_passes", rise_q.size(), 1);
    check("t1_rise", rise_q[0], t0 + 2);
    check("t1_plot_first", plot_first, t0 + 4);
    check("t1_plot_last", plot_last, t0 + 403);
    check("t1_plot_cnt", plot_cnt, 400);
    check("t1_cx", cx_q[0], 3);
    check("t1_cy", cy_q[0], 2);
    check("t1_stable", unstable, 0);

    // out-of-range requests
    clr_mon();
    push(8, 0);
    check("t3_drop_a", int'(dropped), 1);
    check("t3_cnt_a", int'(fifo_count), 0);
    step();
    check("t3_drop_clr", int'(dropped), 0);
    push(0, 6);
    check("t3_drop_b", int'(dropped), 1);
    step(); step();
    check("t3_drop_cnt", drop_cnt, 2);
    check("t3_no_pass", rise_q.size(), 0);
    check("t3_cnt", int'(fifo_count), 0);

    // fill the queue, then push against a full queue while it pops
    clr_mon();
    t0 = cyc_n;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_gx = 4'(i % 8);
      req_gy = 4'(i / 8);
      if (i == 9) check("t2_ready_low", int'(req_ready), 0);
      if (req_ready) acc++;
      step();
    end
    check("t2_accepted", acc, 9);
    check("t2_count_full", int'(fifo_count), 8);
    req_gx = 4'd5; req_gy = 4'd5;
    rdy_full = 0;
    n = 0;
    while (fifo_count == 4'd8 && n < 600) begin
      if (req_ready) rdy_full++;
      step();
      n++;
    end
    req_valid = 1'b0;
    check("t6_full_rdy", rdy_full, 0);
    check("t6_full_pop_cnt", int'(fifo_count), 7);
    check("t6_full_pop_cyc", cyc_n, t0 + 406);
    wait_idle("t2_idle", 9 * 404 + 100);
    check("t2_passes", rise_q.size(), 9);
    check("t2_first_rise", rise_q[0], t0 + 2);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t2_cx%0d", i), cx_q[i], i % 8);
      check($sformatf("t2_cy%0d", i), cy_q[i], i / 8);
      if (i > 0)
        check($sformatf("t2_gap%0d", i), rise_q[i] - rise_q[i-1], 404);
    end
    check("t2_stable", unstable, 0);

    // stale erase_done must not end the pass early
    clr_mon();
    done_mode = 1;
    t0 = cyc_n;
    push(2, 3);
    wait_idle("t4a_idle", 600);
    check("t4a_busy_low_cyc", cyc_n, t0 + 405);
    check("t4a_rise", rise_q[0], t0 + 2);
    check("t4a_plot_first", plot_first, t0 + 4);
    check("t4a_plot_cnt", plot_cnt, 400);
    check("t4a_no_err", seq_cyc, -1);

    // missing erase_done trips the watchdog
    clr_mon();
    done_mode = 2;
    t0 = cyc_n;
    push(1, 1);
    push(6, 5);
    wait_idle("t4b_idle", 1000);
    check("t4b_err_cyc", seq_cyc, t0 + 2 + 402);
    check("t4b_passes", rise_q.size(), 2);
    check("t4b_rise2", rise_q[1], t0 + 2 + 404);
    check("t4b_cx2", cx_q[1], 6);
    check("t4b_cy2", cy_q[1], 5);
    check("t4b_plot_cnt", plot_cnt, 800);
    check("t4b_sticky", int'(seq_error), 1);

    // push+pop at count 4, then reset mid-pass
    clr_mon();
    done_mode = 0;
    t0 = cyc_n;
    for (int i = 0; i < 5; i++) push(i, i % 6);
    while (cyc_n < t0 + 405) step();
    check("t6_idle_cnt", int'(fifo_count), 4);
    check("t6_idle_resetn", int'(erase_resetn), 0);
    push(7, 0);
    check("t6_pp_cnt", int'(fifo_count), 4);
    check("t6_pp_erase", int'(erase_resetn), 1);
    while (cyc_n < t0 + 406 + 100) step();
    check("t5_plot_pre", int'(plot), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_plot", int'(plot), 0);
    check("t5_resetn", int'(erase_resetn), 0);
    check("t5_count", int'(fifo_count), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_seq_error", int'(seq_error), 0);
    step(); step(); step();
    check("t5_no_restart", rise_q.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
